pc_fetch_unit: RTL and testbench

- Parametrised successor to the single-cycle PC/fetch path in the core.
- Owns the program counter and issues pipelined instruction fetches to memory over a request/response interface with arbitrary latency.
- Buffers returned instructions in a prefetch FIFO and presents them to the decoder with a valid/ready handshake.
- Supports redirects (branch/jump) with discard of in-flight responses, and a sticky halt on an all-zero instruction.

---
 rtl/pc_fetch_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter, issues pipelined fetches over a
// request/response memory port and buffers returned words in a prefetch FIFO
// for the decoder. Redirects drop in-flight responses. An all-zero word
// parks the unit in a sticky HALT state.

// Overflow and credit checks for the prefetch FIFO, kept out of the datapath.
module pc_fetch_unit_chk #(
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [CW-1:0] fifo_count,
  input  logic [CW-1:0] outstanding
);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == DEPTH_C)));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (outstanding <= DEPTH_C));
endmodule

module pc_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PC_STEP    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  output logic                  o_fetch_req,
  output logic [ADDR_WIDTH-1:0] o_fetch_addr,
  input  logic                  i_fetch_ready,
  input  logic                  i_fetch_rvalid,
  input  logic [DATA_WIDTH-1:0] i_fetch_rdata,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_instr_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_instr_pc,
  input  logic                  i_instr_ready,
  output logic                  o_halted
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]           DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PC_STEP);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         fifo_count;
  logic [AW-1:0]         fifo_wr;
  logic [AW-1:0]         fifo_rd;
  logic [AW-1:0]         tag_wr;
  logic [AW-1:0]         tag_rd;

  logic [DATA_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] tag_pc     [FIFO_DEPTH];

  logic        running;
  logic        fifo_empty;
  logic        head_zero;
  logic [CW:0] credit_used;
  logic        credit_ok;
  logic        take_redirect;
  logic        fetch_req;
  logic        accept;
  logic        resp;
  logic        push;
  logic        pop;
  logic        instr_valid;
  logic        halt_enter;

  // Handshake and credit decode shared by every state update.
  always_comb begin
    fifo_empty    = (fifo_count == {CW{1'b0}});
    head_zero     = (fifo_instr[fifo_rd] == {DATA_WIDTH{1'b0}});
    credit_used   = {1'b0, outstanding} + {1'b0, fifo_count};
    credit_ok     = (credit_used < DEPTH_C);
    take_redirect = running && i_redirect;
    // Gating with rst_n keeps the request low while reset is held.
    fetch_req     = rst_n && clk_en && running && !i_redirect && credit_ok;
    accept        = fetch_req && i_fetch_ready;
    resp          = clk_en && i_fetch_rvalid;
    // A response is kept only in RUN, outside a redirect, with nothing to discard.
    push          = resp && running && !take_redirect && (discard == {CW{1'b0}});
    // An all-zero head is never offered to the decoder; it triggers HALT instead.
    instr_valid   = running && !fifo_empty && !head_zero;
    pop           = clk_en && instr_valid && i_instr_ready && !take_redirect;
    halt_enter    = running && !fifo_empty && head_zero && !i_redirect;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: HALT is entered from a zero head and never left.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (clk_en && halt_enter) begin
          state_nxt = HALT;
        end else begin
          state_nxt = RUN;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    running = 1'b0;
    case (state)
      RUN:     running = 1'b1;
      HALT:    running = 1'b0;
      default: running = 1'b0;
    endcase
  end

  // PC, credit, discard and pointer bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= {CW{1'b0}};
      discard     <= {CW{1'b0}};
      fifo_count  <= {CW{1'b0}};
      fifo_wr     <= {AW{1'b0}};
      fifo_rd     <= {AW{1'b0}};
      tag_wr      <= {AW{1'b0}};
      tag_rd      <= {AW{1'b0}};
    end else if (clk_en) begin
      if (take_redirect) begin
        pc <= i_redirect_pc;
      end else if (accept) begin
        pc <= pc + STEP_C;
      end

      case ({accept, resp})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      // Everything still in flight at a redirect is stale, including a
      // response landing in the redirect cycle itself.
      if (take_redirect) begin
        discard <= outstanding - (resp ? CW'(1) : CW'(0));
      end else if (resp && (discard != {CW{1'b0}})) begin
        discard <= discard - CW'(1);
      end

      if (accept) begin
        tag_wr <= tag_wr + AW'(1);
      end
      if (resp) begin
        tag_rd <= tag_rd + AW'(1);
      end

      // Flush by moving the read pointer onto the write pointer.
      if (take_redirect) begin
        fifo_rd    <= fifo_wr;
        fifo_count <= {CW{1'b0}};
      end else begin
        if (push) begin
          fifo_wr <= fifo_wr + AW'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + AW'(1);
        end
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // Record the PC of each accepted request so its response can be tagged.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_pc[tag_wr] <= pc;
    end
  end

  // Prefetch FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[fifo_wr] <= i_fetch_rdata;
      fifo_pc[fifo_wr]    <= tag_pc[tag_rd];
    end
  end

  // Output drive; head fields read as zero whenever the head is not valid.
  always_comb begin
    o_fetch_req   = fetch_req;
    o_fetch_addr  = pc;
    o_instr_valid = instr_valid;
    o_halted      = (state == HALT);
    if (instr_valid) begin
      o_instr    = fifo_instr[fifo_rd];
      o_instr_pc = fifo_pc[fifo_rd];
    end else begin
      o_instr    = {DATA_WIDTH{1'b0}};
      o_instr_pc = {ADDR_WIDTH{1'b0}};
    end
  end

  pc_fetch_unit_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .pop         (pop),
    .fifo_count  (fifo_count),
    .outstanding (outstanding)
  );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: an in-order memory model with per-request
// latency and a decoder scoreboard that expects PCs stepping by 4 from the
// last reset or redirect target, each with its memory word.
module tb_pc_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        halted;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .o_fetch_req    (fetch_req),
    .o_fetch_addr   (fetch_addr),
    .i_fetch_ready  (fetch_ready),
    .i_fetch_rvalid (fetch_rvalid),
    .i_fetch_rdata  (fetch_rdata),
    .i_redirect     (redirect),
    .i_redirect_pc  (redirect_pc),
    .o_instr_valid  (instr_valid),
    .o_instr        (instr),
    .o_instr_pc     (instr_pc),
    .i_instr_ready  (instr_ready),
    .o_halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [31:0] cons_pc[$];
  logic [31:0] cons_ins[$];
  int          cyc;
  int          last_due;
  int          lat_lo;
  int          lat_hi;
  logic [31:0] exp_pc;
  logic [31:0] halt_addr;
  int          n_req;
  int          n_acc;
  int          n_cons;
  logic        last_req;
  logic [31:0] last_addr;
  logic        last_valid;
  int          n_checks;
  int          n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return 32'h0000_0000;
    return (a << 5) + 32'h0000_0013;
  endfunction

  task automatic model_reset();
    mq.delete();
    cons_pc.delete();
    cons_ins.delete();
    cyc      = 0;
    last_due = -1;
    exp_pc   = 32'h0000_0000;
    n_req    = 0;
    n_acc    = 0;
    n_cons   = 0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    clk_en       = 1'b1;
    fetch_ready  = 1'b1;
    fetch_rvalid = 1'b0;
    fetch_rdata  = 32'h0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0;
    instr_ready  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: drive memory response, sample before the edge, update model after.
  task automatic cycle();
    logic        acc;
    logic        cons;
    logic        pre_halt;
    logic [31:0] a;
    logic [31:0] h_addr;
    logic [31:0] h_pc;
    logic        h_valid;
    logic        h_halt;
    int          due;
    if (clk_en && (mq.size() > 0) && (mq[0].due <= cyc)) begin
      fetch_rvalid = 1'b1;
      fetch_rdata  = mem_word(mq[0].addr);
    end else begin
      fetch_rvalid = 1'b0;
      fetch_rdata  = 32'h0;
    end
    #1;
    acc        = fetch_req && fetch_ready;
    a          = fetch_addr;
    last_req   = fetch_req;
    last_addr  = fetch_addr;
    last_valid = instr_valid;
    pre_halt   = halted;
    cons       = instr_valid && instr_ready && clk_en && !redirect;
    if (fetch_req) n_req++;
    if (acc) n_acc++;
    if (cons) begin
      check_eq("dec_pc", instr_pc, exp_pc);
      check_eq("dec_instr", instr, mem_word(instr_pc));
      cons_pc.push_back(instr_pc);
      cons_ins.push_back(instr);
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    h_addr  = fetch_addr;
    h_pc    = instr_pc;
    h_valid = instr_valid;
    h_halt  = halted;
    if (!clk_en) check_eq("hold_req", fetch_req, 1'b0);
    @(posedge clk);
    #1;
    if (clk_en) begin
      if (redirect && !pre_halt) exp_pc = redirect_pc;
      if (fetch_rvalid) void'(mq.pop_front());
      if (acc) begin
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: a, due: due});
      end
      cyc++;
    end else begin
      check_eq("hold_addr", fetch_addr, h_addr);
      check_eq("hold_valid", instr_valid, h_valid);
      check_eq("hold_ipc", instr_pc, h_pc);
      check_eq("hold_halt", halted, h_halt);
    end
  endtask

  initial begin
    logic [31:0] addr_hold;
    int          req_snap;
    n_checks  = 0;
    n_errors  = 0;
    halt_addr = 32'hFFFF_FFF0;
    lat_lo    = 1;
    lat_hi    = 1;

    // Reset state and latency-1 streaming.
    rst_n = 1'b0;
    #1;
    do_reset();
    check_eq("rst_req", fetch_req, 1'b0);
    check_eq("rst_addr", fetch_addr, 32'h0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_instr", instr, 32'h0);
    cycle();
    check_eq("t1_req0", last_req, 1'b1);
    check_eq("t1_addr0", last_addr, 32'h0);
    cycle();
    check_eq("t1_addr1", last_addr, 32'h4);
    cycle();
    check_eq("t1_addr2", last_addr, 32'h8);
    repeat (6) cycle();
    check_eq("t1_ncons", (cons_pc.size() >= 3), 1'b1);
    check_eq("t1_pc0", cons_pc[0], 32'h0);
    check_eq("t1_in0", cons_ins[0], 32'h13);
    check_eq("t1_pc1", cons_pc[1], 32'h4);
    check_eq("t1_in1", cons_ins[1], 32'h93);
    check_eq("t1_pc2", cons_pc[2], 32'h8);
    check_eq("t1_in2", cons_ins[2], 32'h113);

    // Decoder stalled: credit limit caps accepted requests at FIFO_DEPTH.
    lat_lo = 3;
    lat_hi = 3;
    do_reset();
    instr_ready = 1'b0;
    repeat (10) cycle();
    check_eq("t2_acc", n_acc, 4);
    check_eq("t2_req_low", fetch_req, 1'b0);
    check_eq("t2_head_valid", instr_valid, 1'b1);
    check_eq("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_req) break;
    end
    check_eq("t2_resume_req", last_req, 1'b1);
    check_eq("t2_resume_addr", last_addr, 32'h10);
    repeat (12) cycle();
    check_eq("t2_drained", (n_cons >= 6), 1'b1);

    // Redirect with two requests in flight.
    do_reset();
    cycle();
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    check_eq("t3_no_req_redirect", last_req, 1'b0);
    redirect = 1'b0;
    cycle();
    check_eq("t3_req_new", last_req, 1'b1);
    check_eq("t3_addr_new", last_addr, 32'h100);
    check_eq("t3_valid_after", last_valid, 1'b0);
    repeat (15) cycle();
    check_eq("t3_got_any", (cons_pc.size() > 0), 1'b1);
    check_eq("t3_first_pc", cons_pc[0], 32'h100);

    // All-zero word at 0xC halts the unit.
    halt_addr = 32'hC;
    lat_lo    = 1;
    lat_hi    = 1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (halted) break;
    end
    check_eq("t4_halted", halted, 1'b1);
    check_eq("t4_ncons", n_cons, 3);
    addr_hold = fetch_addr;
    req_snap  = n_req;
    repeat (5) cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0;
    repeat (4) cycle();
    check_eq("t4_no_req", n_req - req_snap, 0);
    check_eq("t4_addr_hold", fetch_addr, addr_hold);
    check_eq("t4_still_halted", halted, 1'b1);
    check_eq("t4_valid_low", instr_valid, 1'b0);
    check_eq("t4_ncons_after", n_cons, 3);
    halt_addr = 32'hFFFF_FFF0;

    // Random readiness, latency 1..5, clk_en toggling and sparse redirects.
    lat_lo = 1;
    lat_hi = 5;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      fetch_ready = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 1) != 0);
      clk_en      = ($urandom_range(0, 4) != 0);
      if (clk_en && ($urandom_range(0, 39) == 0)) begin
        redirect    = 1'b1;
        redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      end else begin
        redirect = 1'b0;
      end
      cycle();
    end
    redirect = 1'b0;
    clk_en   = 1'b1;
    check_eq("t5_progress", (n_cons > 30), 1'b1);

    // Asynchronous reset mid-stream with requests outstanding.
    lat_lo      = 4;
    lat_hi      = 4;
    fetch_ready = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_req", fetch_req, 1'b0);
    check_eq("t6_addr", fetch_addr, 32'h0);
    check_eq("t6_valid", instr_valid, 1'b0);
    check_eq("t6_halted", halted, 1'b0);
    check_eq("t6_instr", instr, 32'h0);
    model_reset();
    fetch_rvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    check_eq("t6_first_req", last_req, 1'b1);
    check_eq("t6_first_addr", last_addr, 32'h0);
    repeat (20) cycle();
    check_eq("t6_got_any", (cons_pc.size() > 0), 1'b1);
    check_eq("t6_first_pc", cons_pc[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
